// File: rtl/sw_wavefront_sched.sv
// sw_wavefront_sched: anti-diagonal step sequencer for the Smith-Waterman PE array.
// Walks every strip of NPE query rows across the whole reference and drives the
// per-PE enables, the reference/query addressing and the inter-strip H boundary
// buffer. Every output comes straight from a flop.
// Optional feature macro: SW_SCHED_PERF_EN (stall_cycles performance counter).
module sw_wavefront_sched #(
    parameter int unsigned NPE       = 4,
    parameter int unsigned LEN_R     = 64,
    parameter int unsigned LEN_Q     = 48,
    parameter int unsigned DRAIN_CYC = 2,
    localparam int unsigned NSTRIP = LEN_Q / NPE,
    localparam int unsigned NSTEP  = LEN_R + NPE - 1,
    localparam int unsigned SW     = (NSTRIP > 1) ? $clog2(NSTRIP) : 1,
    localparam int unsigned CW     = (NSTEP > 1) ? $clog2(NSTEP) : 1,
    localparam int unsigned AW     = (LEN_R > 1) ? $clog2(LEN_R) : 1,
    localparam int unsigned QW     = (LEN_Q > 1) ? $clog2(LEN_Q) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           step_ready,
    output logic           step_valid,
    output logic [NPE-1:0] pe_en,
    output logic [SW-1:0]  strip,
    output logic [CW-1:0]  col,
    output logic [AW-1:0]  ref_addr,
    output logic [QW-1:0]  qry_base,
    output logic           first_strip,
    output logic           bnd_rd_en,
    output logic [AW-1:0]  bnd_rd_addr,
    output logic           bnd_wr_en,
    output logic [AW-1:0]  bnd_wr_addr,
    output logic           busy,
    output logic           done,
    output logic [15:0]    stall_cycles
);

    localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  strip_q, strip_d;
    logic [CW-1:0]  col_q, col_d;
    logic           valid_q, valid_d;
    logic [DCW-1:0] drain_q, drain_d;

    logic [NPE-1:0] pe_en_q, pe_en_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [QW-1:0]  qry_q, qry_d;
    logic           first_q, first_d;
    logic           rd_en_q, rd_en_d;
    logic           wr_en_q, wr_en_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           commit;

    assign commit = valid_q && step_ready;

    // Next-state logic: step sequencing through strips and columns, drain, done.
    always_comb begin
        state_d = state_q;
        strip_d = strip_q;
        col_d   = col_q;
        valid_d = valid_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    strip_d = '0;
                    col_d   = '0;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                if (commit) begin
                    if (col_q != CW'(NSTEP - 1)) begin
                        col_d = col_q + CW'(1);
                    end else if (strip_q != SW'(NSTRIP - 1)) begin
                        col_d   = '0;
                        strip_d = strip_q + SW'(1);
                    end else begin
                        // strip/col return to zero so the idle address outputs read 0
                        valid_d = 1'b0;
                        col_d   = '0;
                        strip_d = '0;
                        drain_d = '0;
                        state_d = (DRAIN_CYC == 0) ? DONE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(DRAIN_CYC - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Output pre-computation from next state so that every output is a flop.
    always_comb begin
        pe_en_d = '0;
        for (int unsigned k = 0; k < NPE; k++) begin
            pe_en_d[k] = valid_d && (32'(col_d) >= k) && ((32'(col_d) - k) < LEN_R);
        end
        first_d   = valid_d && (strip_d == '0);
        rd_en_d   = pe_en_d[0] && !first_d;
        wr_en_d   = pe_en_d[NPE-1] && (strip_d != SW'(NSTRIP - 1));
        addr_d    = valid_d ? AW'(col_d) : '0;
        wr_addr_d = valid_d ? AW'(col_d - CW'(NPE - 1)) : '0;
        qry_d     = valid_d ? QW'(32'(strip_d) * NPE) : '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    // State and output registers; asynchronous reset aborts any run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            strip_q   <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            drain_q   <= '0;
            pe_en_q   <= '0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            qry_q     <= '0;
            first_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            strip_q   <= strip_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            drain_q   <= drain_d;
            pe_en_q   <= pe_en_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            qry_q     <= qry_d;
            first_q   <= first_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign step_valid  = valid_q;
    assign pe_en       = pe_en_q;
    assign strip       = strip_q;
    assign col         = col_q;
    assign ref_addr    = addr_q;
    assign qry_base    = qry_q;
    assign first_strip = first_q;
    assign bnd_rd_en   = rd_en_q;
    assign bnd_rd_addr = addr_q;
    assign bnd_wr_en   = wr_en_q;
    assign bnd_wr_addr = wr_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef SW_SCHED_PERF_EN
    logic [15:0] stall_q;

    // Saturating count of presented-but-not-accepted steps; cleared when a run starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_q <= '0;
        end else if (valid_q && !step_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sw_wavefront_sched.sv
// Self-checking bench for sw_wavefront_sched: directed vector table on a
// no-stall run, random back-pressure against a bench model, mid-run reset,
// and a parameter-override instance.
module tb_sw_wavefront_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, step_ready;
    logic        step_valid, first_strip, bnd_rd_en, bnd_wr_en, busy, done;
    logic [3:0]  pe_en;
    logic [3:0]  strip;
    logic [6:0]  col;
    logic [5:0]  ref_addr, qry_base, bnd_rd_addr, bnd_wr_addr;
    logic [15:0] stall_cycles;

    logic        p_start, p_ready;
    logic        p_valid, p_first, p_rd_en, p_wr_en, p_busy, p_done;
    logic [7:0]  p_pe_en;
    logic [0:0]  p_strip;
    logic [4:0]  p_col;
    logic [3:0]  p_ref, p_qry, p_rd_addr, p_wr_addr;
    logic [15:0] p_stall;

    sw_wavefront_sched dut (
        .clk(clk), .reset(reset), .start(start), .step_ready(step_ready),
        .step_valid(step_valid), .pe_en(pe_en), .strip(strip), .col(col),
        .ref_addr(ref_addr), .qry_base(qry_base), .first_strip(first_strip),
        .bnd_rd_en(bnd_rd_en), .bnd_rd_addr(bnd_rd_addr), .bnd_wr_en(bnd_wr_en),
        .bnd_wr_addr(bnd_wr_addr), .busy(busy), .done(done), .stall_cycles(stall_cycles)
    );

    sw_wavefront_sched #(.NPE(8), .LEN_R(16), .LEN_Q(16)) dut_p (
        .clk(clk), .reset(reset), .start(p_start), .step_ready(p_ready),
        .step_valid(p_valid), .pe_en(p_pe_en), .strip(p_strip), .col(p_col),
        .ref_addr(p_ref), .qry_base(p_qry), .first_strip(p_first),
        .bnd_rd_en(p_rd_en), .bnd_rd_addr(p_rd_addr), .bnd_wr_en(p_wr_en),
        .bnd_wr_addr(p_wr_addr), .busy(p_busy), .done(p_done), .stall_cycles(p_stall)
    );

    typedef struct {
        int cyc;
        bit valid;
        bit bsy;
        bit dn;
        int strip;
        int col;
        int pe;
        bit first;
        bit rd;
        int rd_addr;
        bit wr;
        int wr_addr;
        int qry;
    } vec_t;

    vec_t vecs[13];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int exp_pe(input int c);
        int r = 0;
        for (int k = 0; k < 4; k++) begin
            if (c >= k && (c - k) < 64) r |= (1 << k);
        end
        return r;
    endfunction

    task automatic apply_vec(input vec_t v);
        string t;
        t = $sformatf("vec@%0d", v.cyc);
        chk({t, ".step_valid"}, step_valid, v.valid);
        chk({t, ".busy"}, busy, v.bsy);
        chk({t, ".done"}, done, v.dn);
        chk({t, ".pe_en"}, pe_en, v.pe);
        chk({t, ".bnd_rd_en"}, bnd_rd_en, v.rd);
        chk({t, ".bnd_wr_en"}, bnd_wr_en, v.wr);
        if (v.valid) begin
            chk({t, ".strip"}, strip, v.strip);
            chk({t, ".col"}, col, v.col);
            chk({t, ".first_strip"}, first_strip, v.first);
            chk({t, ".qry_base"}, qry_base, v.qry);
            if (v.col < 64) chk({t, ".ref_addr"}, ref_addr, v.col);
        end
        if (v.rd) chk({t, ".bnd_rd_addr"}, bnd_rd_addr, v.rd_addr);
        if (v.wr) chk({t, ".bnd_wr_addr"}, bnd_wr_addr, v.wr_addr);
    endtask

    task automatic chk_zero(input string t);
        chk({t, ".step_valid"}, step_valid, 0);
        chk({t, ".pe_en"}, pe_en, 0);
        chk({t, ".strip"}, strip, 0);
        chk({t, ".col"}, col, 0);
        chk({t, ".ref_addr"}, ref_addr, 0);
        chk({t, ".qry_base"}, qry_base, 0);
        chk({t, ".first_strip"}, first_strip, 0);
        chk({t, ".bnd_rd_en"}, bnd_rd_en, 0);
        chk({t, ".bnd_rd_addr"}, bnd_rd_addr, 0);
        chk({t, ".bnd_wr_en"}, bnd_wr_en, 0);
        chk({t, ".bnd_wr_addr"}, bnd_wr_addr, 0);
        chk({t, ".busy"}, busy, 0);
        chk({t, ".done"}, done, 0);
        chk({t, ".stall_cycles"}, stall_cycles, 0);
    endtask

    initial begin
        int commits, done_cnt, done_at, wr_last, busy_fall;
        int e_strip, e_col, e_valid, stalls, last_commit, budget;
        int first_ff, max_col, p_done_cnt;
        bit p_qry_seen;

        //            cyc  v  b  d  strip col  pe  fst rd rda wr wra qry
        vecs[0]  = '{  1,  1, 1, 0,  0,    0,  1,  1,  0, 0,  0, 0,  0};
        vecs[1]  = '{  4,  1, 1, 0,  0,    3, 15,  1,  0, 0,  1, 0,  0};
        vecs[2]  = '{ 65,  1, 1, 0,  0,   64, 14,  1,  0, 0,  1, 61, 0};
        vecs[3]  = '{ 67,  1, 1, 0,  0,   66,  8,  1,  0, 0,  1, 63, 0};
        vecs[4]  = '{ 68,  1, 1, 0,  1,    0,  1,  0,  1, 0,  0, 0,  4};
        vecs[5]  = '{ 71,  1, 1, 0,  1,    3, 15,  0,  1, 3,  1, 0,  4};
        vecs[6]  = '{356,  1, 1, 0,  5,   20, 15,  0,  1, 20, 1, 17, 20};
        vecs[7]  = '{738,  1, 1, 0, 11,    0,  1,  0,  1, 0,  0, 0,  44};
        vecs[8]  = '{741,  1, 1, 0, 11,    3, 15,  0,  1, 3,  0, 0,  44};
        vecs[9]  = '{804,  1, 1, 0, 11,   66,  8,  0,  0, 0,  0, 0,  44};
        vecs[10] = '{805,  0, 1, 0,  0,    0,  0,  0,  0, 0,  0, 0,  0};
        vecs[11] = '{807,  0, 1, 1,  0,    0,  0,  0,  0, 0,  0, 0,  0};
        vecs[12] = '{808,  0, 0, 0,  0,    0,  0,  0,  0, 0,  0, 0,  0};

        reset = 1'b1; start = 1'b0; step_ready = 1'b0;
        p_start = 1'b0; p_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // ---- No-stall full run with vector table ----
        commits = 0; done_cnt = 0; done_at = -1; wr_last = 0; busy_fall = 0;
        cyc = 0; start = 1'b1; step_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 810; t++) begin
            foreach (vecs[i]) if (vecs[i].cyc == cyc) apply_vec(vecs[i]);
            if (step_valid && step_ready) commits++;
            if (done) begin done_cnt++; done_at = cyc; end
            if (bnd_wr_en && strip == 4'd11) wr_last++;
            if (!busy && busy_fall == 0) busy_fall = cyc;
            tick();
        end
        chk("full.commits", commits, 804);
        chk("full.done_pulses", done_cnt, 1);
        chk("full.done_cycle", done_at, 807);
        chk("full.wr_en_in_last_strip", wr_last, 0);
        chk("full.busy_fall", busy_fall, 808);

        // ---- Random back-pressure, stray start pulses, model comparison ----
        e_strip = 0; e_col = 0; e_valid = 1; stalls = 0; commits = 0;
        done_cnt = 0; done_at = -1; last_commit = -1; budget = 0;
        start = 1'b1; step_ready = 1'b0;
        tick();
        start = 1'b0;
        while (budget < 4000) begin
            chk("rnd.step_valid", step_valid, e_valid);
            if (e_valid != 0) begin
                chk("rnd.strip", strip, e_strip);
                chk("rnd.col", col, e_col);
                chk("rnd.pe_en", pe_en, exp_pe(e_col));
            end
            if (done_at >= 0 && budget > done_at) chk("rnd.no_restart", busy, 0);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = budget;
            end
            step_ready = 1'($urandom_range(0, 1));
            start = 1'b0;
            if (e_valid != 0 && $urandom_range(0, 29) == 0) start = 1'b1;
            if (e_valid == 0 && busy && !done) start = 1'b1;
            if (done) start = 1'b1;
            if (e_valid != 0) begin
                if (step_ready) begin
                    commits++;
                    last_commit = budget;
                    if (e_col < 66) e_col++;
                    else if (e_strip < 11) begin e_col = 0; e_strip++; end
                    else e_valid = 0;
                end else begin
                    stalls++;
                end
            end
            tick();
            budget++;
            if (done_at >= 0 && budget > done_at + 3) break;
        end
        start = 1'b0;
        chk("rnd.finished_in_budget", (done_at >= 0) ? 1 : 0, 1);
        chk("rnd.commits", commits, 804);
        chk("rnd.done_pulses", done_cnt, 1);
        chk("rnd.done_latency", done_at - last_commit, 3);
`ifdef SW_SCHED_PERF_EN
        chk("rnd.stall_cycles", stall_cycles, stalls);
`else
        chk("rnd.stall_cycles", stall_cycles, 0);
`endif

        // ---- Reset in the middle of strip 5 ----
        step_ready = 1'b1;
        cyc = 0; start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < 356) tick();
        chk("mid.strip", strip, 5);
        chk("mid.col", col, 20);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        done_cnt = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (done) done_cnt++;
            chk("post_reset.busy", busy, 0);
        end
        chk("post_reset.no_done", done_cnt, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.step_valid", step_valid, 1);
        chk("restart.strip", strip, 0);
        chk("restart.col", col, 0);
        chk("restart.pe_en", pe_en, 1);

        // ---- Parameter override NPE=8, LEN_R=16, LEN_Q=16 ----
        commits = 0; first_ff = -1; max_col = 0; p_done_cnt = 0; p_qry_seen = 1'b0;
        p_ready = 1'b1; p_start = 1'b1;
        tick();
        p_start = 1'b0;
        for (int t = 0; t < 80; t++) begin
            if (p_valid) begin
                commits++;
                if (int'(p_col) > max_col) max_col = int'(p_col);
                if (p_pe_en == 8'hFF && first_ff < 0) first_ff = int'(p_col);
                if (p_strip == 1'b1 && p_col == 5'd0) begin
                    chk("par.qry_base_strip1", p_qry, 8);
                    p_qry_seen = 1'b1;
                end
            end
            if (p_done) p_done_cnt++;
            tick();
        end
        chk("par.commits", commits, 46);
        chk("par.first_all_pe_col", first_ff, 7);
        chk("par.max_col", max_col, 22);
        chk("par.done_pulses", p_done_cnt, 1);
        chk("par.strip1_seen", p_qry_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_wavefront_sched.md
# sw_wavefront_sched

Wavefront scheduler for the Smith-Waterman systolic PE array. The query is split into strips of NPE rows, one query base per PE, and the reference is streamed column by column through each strip. The scheduler sequences every anti-diagonal step and drives the per-PE enables, the reference and query addressing, and the inter-strip H boundary buffer. It sits between the sequence-load logic and the PE array / max-tracking datapath.

## Interface
- NPE, 4, number of PEs (query rows per strip); must divide LEN_Q
- LEN_R, 64, reference length
- LEN_Q, 48, query length
- DRAIN_CYC, 2, cycles waited after the last step for the datapath pipeline to settle
- Derived values (local):
  - NSTRIP = LEN_Q/NPE = 12
  - NSTEP = LEN_R+NPE-1 = 67
  - SW = $clog2(NSTRIP) = 4
  - CW = $clog2(NSTEP) = 7
  - AW = $clog2(LEN_R) = 6

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  run request; sequences already loaded; sampled only in IDLE
- step_ready  in  1  datapath accepts the current step
- step_valid  out  1  current step presented
- pe_en  out  NPE  per-PE compute enable for current step
- strip  out  SW  current strip index
- col  out  CW  step index within strip
- ref_addr  out  AW  reference index fed to PE0 (= col while col < LEN_R)
- qry_base  out  $clog2(LEN_Q)  first query row of strip (= strip*NPE)
- first_strip  out  1  strip==0; datapath uses zero top boundary
- bnd_rd_en  out  1  read H boundary for PE0
- bnd_rd_addr  out  AW  = col
- bnd_wr_en  out  1  write bottom-row H from PE NPE-1
- bnd_wr_addr  out  AW  = col-(NPE-1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- stall_cycles  out  16  stall counter (see Configuration)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start=1, go to RUN with strip=0, col=0, step_valid=1.
- RUN: a step commits when step_valid && step_ready.
  - On commit with col<NSTEP-1: col+1.
  - On commit with col==NSTEP-1 and strip<NSTRIP-1: col=0, strip+1.
  - On commit with col==NSTEP-1 and strip==NSTRIP-1: go to DRAIN, step_valid=0.
- DRAIN: count DRAIN_CYC cycles, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- pe_en[k] = step_valid && col>=k && (col-k)<LEN_R.
- bnd_rd_en = pe_en[0] && !first_strip.
- bnd_wr_en = pe_en[NPE-1] && strip!=NSTRIP-1.
- Boundary buffer writes are committed by the datapath only when step_ready=1.
- All address outputs are computed from registered strip/col. Address outputs are don't-care when their enable is 0, but are driven as the zero-extended truncated value, never X.
- start while busy is ignored and never queued.
- start in the DONE cycle is ignored.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset mid-run aborts immediately: outputs 0, no done pulse.
- All outputs are registered.
- start accepted at edge N gives step_valid=1 at cycle N+1.
- step_ready=0 holds strip, col, pe_en and all addresses stable; step_valid stays 1.
- Latency with step_ready tied to 1:
  - NSTRIP*NSTEP = 804 RUN cycles.
  - Then DRAIN_CYC cycles.
  - done asserted at cycle N+1+804+DRAIN_CYC.
- busy is 1 from N+1 through the done cycle inclusive.
- Strip wrap takes no bubble: the cycle after commit of col=66 shows col=0 at the next strip.

## Configuration
- SW_SCHED_PERF_EN:
  - Defined: stall_cycles counts cycles with step_valid && !step_ready, saturating at 16'hFFFF. It clears on start acceptance and holds its value after done.
  - Undefined: stall_cycles is tied to 0 and the counter logic is absent.

## Test plan
- Defaults, step_ready=1, start pulse at cycle 0:
  - Cycle 1: col=0, strip=0, pe_en=4'b0001, first_strip=1, bnd_rd_en=0.
  - Cycle 4: col=3, pe_en=4'b1111, bnd_wr_en=1, bnd_wr_addr=0.
  - Cycle 67: col=66, pe_en=4'b1000, bnd_wr_addr=63.
  - Cycle 68: strip=1, col=0, bnd_rd_en=1, bnd_rd_addr=0.
- Full run, step_ready=1:
  - Exactly 804 commits.
  - done=1 only at cycle 807 (DRAIN_CYC=2).
  - bnd_wr_en never 1 during strip 11.
  - busy falls at cycle 808.
- Random step_ready at 50%:
  - Outputs stable while step_ready=0.
  - Commit sequence identical to the no-stall run.
  - With SW_SCHED_PERF_EN, stall_cycles equals the bench-counted stalls.
- start pulses during RUN, DRAIN and DONE: no restart, done pulses exactly once.
- reset asserted at strip=5, col=20: all outputs 0 immediately. A new start afterwards begins at strip=0, col=0.
- Parameter override NPE=8, LEN_R=16, LEN_Q=16: NSTEP=23, 46 commits, pe_en=8'hFF first at col=7.
